// File: rtl/ascon_blk_feeder.sv
// ascon_blk_feeder
//   Input stage for the Ascon control FSM. It takes 32-bit big-endian words
//   from the register/bus side and packs them into 64-bit rate blocks. The
//   final block of each AD/PT segment gets 10* padding. Blocks are queued in
//   a small FIFO and handed to the FSM on a data_req_i / data_valid_o
//   handshake.
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   start_i             new message: flush FIFO, assembler, pending request, counters
//   wr_valid_i/ready_o  upstream word handshake
//   wr_data_i           word, byte 0 in [31:24]
//   wr_last_i           final word of the segment
//   wr_nbytes_i         valid bytes (1..4) of a last word; 0 or >4 means 4
//   data_req_i          one-cycle block request from the FSM
//   data_valid_o        one-cycle pulse answering a request
//   data_o              block register, changes only on a pop
//   fifo_cnt_o          FIFO occupancy
//   blk_cnt_o           saturating count of blocks pushed since start
//   err_o               sticky: request arrived while one was already pending
module ascon_blk_feeder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [31:0]                wr_data_i,
  input  logic                       wr_last_i,
  input  logic [2:0]                 wr_nbytes_i,
  input  logic                       data_req_i,
  output logic                       data_valid_o,
  output logic [63:0]                data_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_cnt_o,
  output logic [CNT_W-1:0]           blk_cnt_o,
  output logic                       err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [63:0] PAD_BLK = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {ASM_HI, ASM_LO, PAD} asm_state_t;

  logic [63:0]      mem [DEPTH];
  asm_state_t       asm_state_reg, asm_state_next;
  logic [31:0]      hi_reg, hi_next;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    cnt_reg;
  logic             pending_reg;
  logic             err_reg;
  logic             valid_reg;
  logic [63:0]      data_reg;
  logic [CNT_W-1:0] blk_cnt_reg;

  logic        full, empty, word_fire, push, pop;
  logic [2:0]  nbytes_eff;
  logic [63:0] tail_blk, push_blk;

  // Keep the first n bytes of a word, append the 0x80 marker, zero-fill to 64 bits.
  function automatic logic [63:0] pad_tail(input logic [31:0] w, input logic [2:0] n);
    case (n)
      3'd1:    pad_tail = {w[31:24], 8'h80, 48'h0};
      3'd2:    pad_tail = {w[31:16], 8'h80, 40'h0};
      3'd3:    pad_tail = {w[31:8],  8'h80, 32'h0};
      default: pad_tail = {w,        8'h80, 24'h0};
    endcase
  endfunction

  assign full       = (cnt_reg == CW'(DEPTH));
  assign empty      = (cnt_reg == '0);
  assign wr_ready_o = !rst_i && !start_i && !full && (asm_state_reg != PAD);
  assign word_fire  = wr_valid_i && wr_ready_o;
  assign nbytes_eff = (wr_nbytes_i == 3'd0 || wr_nbytes_i > 3'd4) ? 3'd4 : wr_nbytes_i;
  assign tail_blk   = pad_tail(wr_data_i, nbytes_eff);

  // A request in the current cycle counts immediately, giving one-cycle latency.
  assign pop = !start_i && (pending_reg || data_req_i) && !empty;

  always_comb begin
    push           = 1'b0;
    push_blk       = tail_blk;
    asm_state_next = asm_state_reg;
    hi_next        = hi_reg;
    case (asm_state_reg)
      ASM_HI: begin
        if (word_fire) begin
          if (wr_last_i) begin
            push = 1'b1;
          end else begin
            hi_next        = wr_data_i;
            asm_state_next = ASM_LO;
          end
        end
      end
      ASM_LO: begin
        if (word_fire) begin
          push           = 1'b1;
          asm_state_next = ASM_HI;
          if (!wr_last_i) begin
            push_blk = {hi_reg, wr_data_i};
          end else if (nbytes_eff == 3'd4) begin
            // Full final block: the padding needs a block of its own.
            push_blk       = {hi_reg, wr_data_i};
            asm_state_next = PAD;
          end else begin
            push_blk = {hi_reg, tail_blk[63:32]};
          end
        end
      end
      PAD: begin
        if (!start_i && !full) begin
          push           = 1'b1;
          push_blk       = PAD_BLK;
          asm_state_next = ASM_HI;
        end
      end
      default: asm_state_next = ASM_HI;
    endcase
  end

  // Storage array without reset so it maps onto RAM; read is registered into data_reg.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_blk;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      asm_state_reg <= ASM_HI;
      hi_reg        <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      cnt_reg       <= '0;
      pending_reg   <= 1'b0;
      err_reg       <= 1'b0;
      valid_reg     <= 1'b0;
      data_reg      <= '0;
      blk_cnt_reg   <= '0;
    end else if (start_i) begin
      asm_state_reg <= ASM_HI;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      cnt_reg       <= '0;
      pending_reg   <= 1'b0;
      err_reg       <= 1'b0;
      valid_reg     <= 1'b0;
      blk_cnt_reg   <= '0;
    end else begin
      asm_state_reg <= asm_state_next;
      hi_reg        <= hi_next;
      valid_reg     <= pop;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (blk_cnt_reg != '1) begin
          blk_cnt_reg <= blk_cnt_reg + 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        data_reg   <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
      // A request arriving while one is already pending keeps it pending.
      if (pop) begin
        pending_reg <= pending_reg && data_req_i;
      end else if (data_req_i) begin
        pending_reg <= 1'b1;
      end
      if (data_req_i && pending_reg) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign data_valid_o = valid_reg;
  assign data_o       = data_reg;
  assign fifo_cnt_o   = cnt_reg;
  assign blk_cnt_o    = blk_cnt_reg;
  assign err_o        = err_reg;

endmodule

// File: tb/tb_ascon_blk_feeder.sv
// Directed bench for ascon_blk_feeder. Expected blocks are queued when the
// completing word is driven and compared when data_valid_o pulses. Inputs
// change on the falling edge; outputs are sampled on the falling edge or
// 1 ns after it.
module tb_ascon_blk_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        wr_last = 1'b0;
  logic [2:0]  wr_nbytes = 3'd4;
  logic        data_req = 1'b0;
  logic        data_valid;
  logic [63:0] data;
  logic [1:0]  fifo_cnt;
  logic [7:0]  blk_cnt;
  logic        err;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  logic [63:0] exp_q[$];

  ascon_blk_feeder #(.DEPTH(2), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .wr_last_i(wr_last), .wr_nbytes_i(wr_nbytes),
    .data_req_i(data_req), .data_valid_o(data_valid), .data_o(data),
    .fifo_cnt_o(fifo_cnt), .blk_cnt_o(blk_cnt), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest expected block.
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      nvalid++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_valid observed=%h expected=<none>", data);
      end
      if (exp_q.size() != 0) begin
        chk("sb_block", data, exp_q.pop_front());
      end
    end
  end

  // Present one word and hold it until accepted (bounded).
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] n);
    int  waited = 0;
    logic done = 1'b0;
    wr_data = d; wr_last = last; wr_nbytes = n; wr_valid = 1'b1;
    while (!done) begin
      #1;
      if (wr_ready) done = 1'b1;
      @(negedge clk);
      if (!done) begin
        waited++;
        if (waited > 50) begin
          checks++;
          errors++;
          $error("FAIL send_timeout observed=no_ready expected=ready word=%h", d);
          done = 1'b1;
        end
      end
    end
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic do_req();
    data_req = 1'b1;
    @(negedge clk);
    data_req = 1'b0;
  endtask

  logic [63:0] d_before;
  int          nvalid_before;

  initial begin
    // Reset state
    #2;
    chk("rst_ready", 64'(wr_ready), 64'd0);
    chk("rst_valid", 64'(data_valid), 64'd0);
    chk("rst_data", data, 64'd0);
    chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full final block followed by a pad block
    send_word(32'h0001_0203, 1'b0, 3'd4);
    exp_q.push_back(64'h0001_0203_0405_0607);
    exp_q.push_back(64'h8000_0000_0000_0000);
    send_word(32'h0405_0607, 1'b1, 3'd4);
    #1;
    chk("pad_ready_low", 64'(wr_ready), 64'd0);
    chk("pad_fifo_cnt", 64'(fifo_cnt), 64'd1);
    chk("pad_blk_cnt1", 64'(blk_cnt), 64'd1);
    @(negedge clk);
    chk("pad_blk_cnt2", 64'(blk_cnt), 64'd2);
    chk("pad_fifo_full", 64'(fifo_cnt), 64'd2);
    #1;
    chk("full_ready_low", 64'(wr_ready), 64'd0);
    @(negedge clk);
    do_req();
    #1;
    chk("after_pop_cnt", 64'(fifo_cnt), 64'd1);
    chk("after_pop_ready", 64'(wr_ready), 64'd1);
    do_req();
    @(negedge clk);
    chk("drained_cnt", 64'(fifo_cnt), 64'd0);

    // Partial single-word block, one-cycle request latency
    exp_q.push_back(64'hAABB_CC80_0000_0000);
    send_word(32'hAABB_CCDD, 1'b1, 3'd3);
    do_req();
    chk("lat1_valid", 64'(data_valid), 64'd1);
    chk("lat1_data", data, 64'hAABB_CC80_0000_0000);
    @(negedge clk);
    chk("lat1_valid_drop", 64'(data_valid), 64'd0);

    // Request waits on an empty FIFO
    do_req();
    repeat (5) @(negedge clk);
    chk("wait_no_valid", 64'(data_valid), 64'd0);
    send_word(32'h1122_3344, 1'b0, 3'd4);
    exp_q.push_back(64'h1122_3344_5566_8000);
    send_word(32'h5566_7788, 1'b1, 3'd2);
    chk("wait_not_yet", 64'(data_valid), 64'd0);
    @(negedge clk);
    chk("wait_valid", 64'(data_valid), 64'd1);
    chk("wait_err", 64'(err), 64'd0);

    // Full FIFO back-pressure: occupancy 2,1,2
    exp_q.push_back(64'h1280_0000_0000_0000);
    send_word(32'h1234_5678, 1'b1, 3'd1);
    exp_q.push_back(64'h9A80_0000_0000_0000);
    send_word(32'h9ABC_DEF0, 1'b1, 3'd1);
    exp_q.push_back(64'h3456_8000_0000_0000);
    wr_data = 32'h3456_789A; wr_last = 1'b1; wr_nbytes = 3'd2; wr_valid = 1'b1;
    data_req = 1'b1;
    #1;
    chk("bp_ready_low", 64'(wr_ready), 64'd0);
    chk("bp_cnt_a", 64'(fifo_cnt), 64'd2);
    @(negedge clk);
    data_req = 1'b0;
    #1;
    chk("bp_cnt_b", 64'(fifo_cnt), 64'd1);
    chk("bp_ready_high", 64'(wr_ready), 64'd1);
    @(negedge clk);
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("bp_cnt_c", 64'(fifo_cnt), 64'd2);
    do_req();
    do_req();
    @(negedge clk);
    chk("bp_drained", 64'(fifo_cnt), 64'd0);

    // Double request -> sticky error, single answer; nbytes=0 means 4
    nvalid_before = nvalid;
    do_req();
    do_req();
    chk("err_set", 64'(err), 64'd1);
    exp_q.push_back(64'hCAFE_F00D_8000_0000);
    send_word(32'hCAFE_F00D, 1'b1, 3'd0);
    repeat (4) @(negedge clk);
    chk("err_single_valid", 64'(nvalid), 64'(nvalid_before + 1));
    chk("err_sticky", 64'(err), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_err_clr", 64'(err), 64'd0);
    chk("start_blk_clr", 64'(blk_cnt), 64'd0);

    // start_i mid-block with one block queued
    send_word(32'h0BAD_CAFE, 1'b1, 3'd4);
    send_word(32'hDEAD_BEEF, 1'b0, 3'd4);
    d_before = data;
    start = 1'b1;
    wr_data = 32'h7777_7777; wr_last = 1'b0; wr_valid = 1'b1;
    #1;
    chk("start_ready_low", 64'(wr_ready), 64'd0);
    @(negedge clk);
    start = 1'b0; wr_valid = 1'b0;
    chk("start_fifo_cnt", 64'(fifo_cnt), 64'd0);
    chk("start_blk_cnt", 64'(blk_cnt), 64'd0);
    chk("start_data_kept", data, d_before);
    chk("start_valid_low", 64'(data_valid), 64'd0);
    send_word(32'h0102_0304, 1'b0, 3'd4);
    exp_q.push_back(64'h0102_0304_0580_0000);
    send_word(32'h0506_0708, 1'b1, 3'd1);
    chk("start_new_blk_cnt", 64'(blk_cnt), 64'd1);
    do_req();
    chk("start_new_valid", 64'(data_valid), 64'd1);

    // Asynchronous reset while in PAD
    send_word(32'hAAAA_AAAA, 1'b0, 3'd4);
    send_word(32'hBBBB_BBBB, 1'b1, 3'd4);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_data", data, 64'd0);
    chk("arst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    chk("arst_blk_cnt", 64'(blk_cnt), 64'd0);
    chk("arst_ready", 64'(wr_ready), 64'd0);
    chk("arst_valid", 64'(data_valid), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("arst_ready_back", 64'(wr_ready), 64'd1);
    chk("arst_cnt_stays", 64'(fifo_cnt), 64'd0);

    chk("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
